// File: rtl/serializer_10bit_tx.sv
// serializer_10bit_tx
// Fabric-side transmit serializer feeding an ODDR. Each 10-bit word goes out
// as five bit-pairs, MSB first. The first pair of every word is driven in the
// cycle after the word is loaded.
// After reset, or on request, a burst of training words is sent so the far-end
// receiver can bitslip-align. In DATA state an idle word is inserted whenever
// no input word is offered at a word boundary, and each one is counted.
//
// Ports:
//   clock            bit-pair clock; all logic on the rising edge
//   reset            synchronous, active-low
//   input_word       word to transmit
//   input_valid      input_word is valid
//   input_ready      word is taken this cycle if input_valid is high
//   training_request single-cycle pulse that starts a new training burst
//   output_bits      [1] = earlier bit (ODDR D1), [0] = later bit (D2)
//   word_strobe      high while output_bits carries bits 9:8 of a word
//   training_active  the word on output_bits is a training word
//   underflow_count  saturating count of idle words inserted in DATA state

module serializer_10bit_tx #(
    parameter logic [9:0]  TRAINING_PATTERN = 10'b1111100000,
    parameter int unsigned TRAINING_WORDS   = 16,
    parameter logic [9:0]  IDLE_PATTERN     = 10'b0011111010
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] input_word,
    input  logic       input_valid,
    output logic       input_ready,
    input  logic       training_request,
    output logic [1:0] output_bits,
    output logic       word_strobe,
    output logic       training_active,
    output logic [7:0] underflow_count
);

    typedef enum logic {
        TRAIN = 1'b0,
        DATA  = 1'b1
    } state_t;

    localparam logic [7:0] TRAIN_LAST = 8'(TRAINING_WORDS);

    logic [2:0] phase_q, phase_d;
    logic [9:0] sr_q, sr_d;
    state_t     state_q, state_d;
    logic [7:0] tcount_q, tcount_d;
    logic       pending_q, pending_d;
    logic       word_strobe_q, word_strobe_d;
    logic       training_active_q, training_active_d;
    logic [7:0] underflow_q, underflow_d;

    logic boundary;

    assign boundary = (phase_q == 3'd4);

    // A pending or same-cycle training request always wins the boundary, so
    // the source is never told it can hand over a word that would be dropped.
    assign input_ready = boundary && (state_q == DATA) && !pending_q && !training_request;

    assign output_bits     = sr_q[9:8];
    assign word_strobe     = word_strobe_q;
    assign training_active = training_active_q;
    assign underflow_count = underflow_q;

    // Next-state logic: shift two bits per clock inside a word, pick the
    // next word at each boundary.
    always_comb begin
        phase_d           = phase_q + 3'd1;
        sr_d              = {sr_q[7:0], 2'b00};
        state_d           = state_q;
        tcount_d          = tcount_q;
        pending_d         = pending_q;
        word_strobe_d     = 1'b0;
        training_active_d = training_active_q;
        underflow_d       = underflow_q;

        if (!boundary) begin
            if (training_request) begin
                pending_d = 1'b1;
            end
        end else begin
            phase_d       = 3'd0;
            word_strobe_d = 1'b1;
            if (pending_q || training_request) begin
                // Restart the burst; this load already counts as word 1.
                sr_d              = TRAINING_PATTERN;
                tcount_d          = 8'd1;
                state_d           = (TRAIN_LAST == 8'd1) ? DATA : TRAIN;
                pending_d         = 1'b0;
                training_active_d = 1'b1;
            end else if (state_q == TRAIN) begin
                // Compare after increment so exactly TRAINING_WORDS go out.
                sr_d              = TRAINING_PATTERN;
                tcount_d          = tcount_q + 8'd1;
                training_active_d = 1'b1;
                if (tcount_q + 8'd1 == TRAIN_LAST) begin
                    state_d = DATA;
                end
            end else if (input_valid) begin
                sr_d              = input_word;
                training_active_d = 1'b0;
            end else begin
                sr_d              = IDLE_PATTERN;
                training_active_d = 1'b0;
                if (underflow_q != 8'hFF) begin
                    underflow_d = underflow_q + 8'd1;
                end
            end
        end
    end

    // Phase resets to 4 so the first clock after release is a boundary that
    // loads the first training word.
    always_ff @(posedge clock) begin
        if (!reset) begin
            phase_q           <= 3'd4;
            sr_q              <= 10'd0;
            state_q           <= TRAIN;
            tcount_q          <= 8'd0;
            pending_q         <= 1'b0;
            word_strobe_q     <= 1'b0;
            training_active_q <= 1'b0;
            underflow_q       <= 8'd0;
        end else begin
            phase_q           <= phase_d;
            sr_q              <= sr_d;
            state_q           <= state_d;
            tcount_q          <= tcount_d;
            pending_q         <= pending_d;
            word_strobe_q     <= word_strobe_d;
            training_active_q <= training_active_d;
            underflow_q       <= underflow_d;
        end
    end

endmodule
